// File: rtl/imem_loader_pkg.sv
// Shared widths, NOP encoding and FSM state encodings for the PE instruction
// memory loader.
package imem_loader_pkg;

  localparam int IMEM_WORD_W  = 32;
  localparam int IMEM_INSTR_W = 128;
  localparam int IMEM_DEPTH   = 1024;
  localparam int IMEM_ADDR_W  = 10;
  localparam int IMEM_BEATS   = IMEM_INSTR_W / IMEM_WORD_W;

  localparam logic [IMEM_INSTR_W-1:0] IMEM_NOP = '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// Program word stream into the instruction memory loader (valid/ready).
interface imem_loader_if #(
  parameter int WORD_W = imem_loader_pkg::IMEM_WORD_W
);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/imem_beat_packer.sv
// Packs four stream words into one instruction, word 0 in the LSBs; a short
// final instruction is zero-padded, which decodes as NOP.
module imem_beat_packer #(
  parameter int WORD_W  = 32,
  parameter int INSTR_W = 128
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               beat_valid,
  input  logic [WORD_W-1:0]  beat_data,
  input  logic               beat_last,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst
);

  logic [1:0]         beat_idx;
  logic [INSTR_W-1:0] asm_q;
  logic [INSTR_W-1:0] asm_next;

  always_comb begin
    asm_next = asm_q;
    asm_next[int'(beat_idx)*WORD_W +: WORD_W] = beat_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_idx   <= 2'd0;
      asm_q      <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
    end else if (clr) begin
      beat_idx   <= 2'd0;
      asm_q      <= '0;
      inst_valid <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      if (beat_valid) begin
        if (beat_idx == 2'd3 || beat_last) begin
          // assembly register restarts empty so the next short instruction pads with zeros
          inst       <= asm_next;
          inst_valid <= 1'b1;
          beat_idx   <= 2'd0;
          asm_q      <= '0;
        end else begin
          asm_q    <= asm_next;
          beat_idx <= beat_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a program into the PE instruction memory, then releases the PE reset.
// Optional IMEM_LOADER_NOP_FILL_EN zeroes every address past the program before done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WORD_W  = IMEM_WORD_W,
  parameter int INSTR_W = IMEM_INSTR_W,
  parameter int DEPTH   = IMEM_DEPTH,
  parameter int ADDR_W  = IMEM_ADDR_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load_start,
  imem_loader_if.slave       s,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               pe_rstn,
  output logic [ADDR_W:0]    instr_count,
  output logic               err_overflow
);

  // state | meaning
  // IDLE  | after reset, PE held in reset, waiting for load_start
  // LOAD  | accepting stream words, writing packed instructions
  // FILL  | zero-writing addresses past the program (NOP fill build only)
  // DONE  | program loaded, PE released, waiting for a new load_start

  logic [1:0]         state;
  logic [ADDR_W-1:0]  wr_addr;
  logic               inst_valid;
  logic [INSTR_W-1:0] inst;
  logic               start;
  logic               accept;
  logic               full;
  logic               prog_we;
  logic               fill_we;

  assign start     = load_start && (state == ST_IDLE || state == ST_DONE);
  assign s.s_ready = (state == ST_LOAD);
  assign accept    = s.s_valid && s.s_ready;
  assign full      = (instr_count == (ADDR_W+1)'(DEPTH));

  imem_beat_packer #(
    .WORD_W  (WORD_W),
    .INSTR_W (INSTR_W)
  ) u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (start),
    .beat_valid (accept),
    .beat_data  (s.s_data),
    .beat_last  (s.s_last),
    .inst_valid (inst_valid),
    .inst       (inst)
  );

  // the last program instruction lands one cycle after s_last, so it may
  // still be pending in the first FILL or DONE cycle
  assign prog_we = inst_valid && !full;
`ifdef IMEM_LOADER_NOP_FILL_EN
  logic at_top;
  assign at_top  = (wr_addr == ADDR_W'(DEPTH-1));
  assign fill_we = (state == ST_FILL) && !inst_valid && !full;
`else
  assign fill_we = 1'b0;
`endif

  assign mem_we    = prog_we || fill_we;
  assign mem_addr  = wr_addr;
  assign mem_wdata = fill_we ? INSTR_W'(IMEM_NOP) : inst;
  assign busy      = (state == ST_LOAD) || (state == ST_FILL);
  assign done      = (state == ST_DONE) && !inst_valid;
  assign pe_rstn   = done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      wr_addr      <= '0;
      instr_count  <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (mem_we) begin
        wr_addr <= wr_addr + 1'b1;
        if (prog_we) instr_count <= instr_count + 1'b1;
      end
      if ((accept || inst_valid) && full) err_overflow <= 1'b1;

      case (state)
        ST_IDLE: if (start) state <= ST_LOAD;
        ST_LOAD: begin
          if (accept && s.s_last) begin
`ifdef IMEM_LOADER_NOP_FILL_EN
            state <= ST_FILL;
`else
            state <= ST_DONE;
`endif
          end
        end
`ifdef IMEM_LOADER_NOP_FILL_EN
        ST_FILL: if (full || (mem_we && at_top)) state <= ST_DONE;
`endif
        ST_DONE: if (start) state <= ST_LOAD;
        default: state <= ST_IDLE;
      endcase

      if (start) begin
        wr_addr      <= '0;
        instr_count  <= '0;
        err_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the PE instruction memory: accepts a program as a stream of 32-bit words over a valid/ready handshake and packs four words per 128-bit instruction. It writes each instruction into the instruction ROM block at consecutive addresses from 0, then releases the PE from reset. It replaces the simulation-only `$readmemh` preload, so the same image can be loaded in hardware.

## Interface
- `WORD_W`, 32: stream word width.
- `INSTR_W`, 128: instruction width; must equal `4*WORD_W`.
- `DEPTH`, 1024: instruction memory depth in instructions.
- `ADDR_W`, 10: memory address width; `2**ADDR_W >= DEPTH`.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `load_start`  in  1  single-cycle request to begin a load.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  stream word ready.
- `s_data`  in  `WORD_W`  stream word.
- `s_last`  in  1  marks the final word of the program.
- `mem_we`  out  1  instruction memory write enable.
- `mem_addr`  out  `ADDR_W`  write address.
- `mem_wdata`  out  `INSTR_W`  packed instruction.
- `busy`  out  1  a load is in progress.
- `done`  out  1  load finished; held until the next `load_start`.
- `pe_rstn`  out  1  active-low reset to the PE; low until `done`.
- `instr_count`  out  `ADDR_W+1`  number of program instructions written.
- `err_overflow`  out  1  sticky flag: the program exceeded `DEPTH`.

## Operation
States: IDLE, LOAD, FILL (only with the macro), DONE.

Reset values:
- All outputs are 0, including `pe_rstn`, so the PE is held in reset.
- FSM state is IDLE.

State transitions:
- IDLE or DONE + `load_start`: go to LOAD on the next cycle. Clear `done`, `instr_count`, `err_overflow`, the beat index and the write address. `pe_rstn` drops to 0.
- `load_start` while in LOAD or FILL: ignored.

LOAD:
- `s_ready` = 1 whenever the state is LOAD. A beat is accepted when `s_valid & s_ready`.
- Accepted beat k (k = 0..3) goes to `inst[32k+31:32k]`, so word 0 is the LSB word.
- On beat 3, or on `s_last`, the packed instruction is registered. Unfilled upper words are zero, which decodes as NOP.
- One cycle after such a beat: `mem_we` = 1 with `mem_addr` = current address. The address then increments and `instr_count` increments. The beat index returns to 0.
- Overflow: when `instr_count == DEPTH`, further words are still accepted but dropped. No write occurs and `err_overflow` is set.
- `s_last` on an accepted beat ends LOAD. The next state is FILL (with the macro) or DONE.

FILL:
- One zero-data write per cycle at each address from `instr_count` to `DEPTH-1`.
- `instr_count` does not change.
- Go to DONE after the write to `DEPTH-1`.
- If the program already filled the memory, go directly to DONE.

DONE:
- `done` = 1 and `pe_rstn` = 1.

`busy` = 1 in LOAD and FILL.

## Timing
- Throughput: one word per cycle, so one instruction write every 4 cycles at full rate.
- Gaps in `s_valid` stall packing and lose no data.
- Latency: accepting the final beat of an instruction → `mem_we` on the next cycle.
- Final `mem_we` → `done` and `pe_rstn` high on the next cycle.
- `mem_we` is a single-cycle pulse per instruction. `mem_addr` and `mem_wdata` are valid only while `mem_we` is 1.
- Asynchronous reset mid-load: all outputs return to their reset values immediately and the partial program is abandoned. Only a new `load_start` resumes loading.
- `load_start` and `s_valid` in the same IDLE cycle: the word is not accepted, because `s_ready` is still 0.

## Configuration
- Macro `IMEM_LOADER_NOP_FILL_EN`.
  - Defined: the FILL state is compiled in. All addresses past the program are zeroed before `done`.
  - Undefined: no FILL state. DONE follows the last program write, and stale memory contents past the program are left untouched.

## Structure
- Shared defines go in the processing-element defines include:
  - instruction width, word width, IMEM depth and address width;
  - the NOP encoding (all zeros);
  - FSM state encodings.
- One sub-module, `imem_beat_packer`: beat index counter plus the 128-bit assembly register with zero-pad on `s_last`. It outputs `inst_valid` and `inst`.
- The top level holds the FSM, address and count counters, and the error flag.

## Test plan
- Reset: after `rstn` is released, check `pe_rstn`=0, `s_ready`=0, `mem_we`=0, `done`=0 and `instr_count`=0.
- Basic load: pulse `load_start`, then send 8 beats 0x00000001..0x00000008 with `s_last` on beat 8.
  - Write to addr 0 = 0x00000004_00000003_00000002_00000001.
  - Write to addr 1 = 0x00000008_00000007_00000006_00000005.
  - `done` and `pe_rstn` rise 1 cycle after the second write; `instr_count`=2.
- Partial instruction: send 6 beats with `s_last` on beat 6 → addr 1 = 0x00000000_00000000_00000006_00000005.
- Stall: insert random `s_valid` gaps into the basic load → identical writes and count.
- Overflow with `DEPTH`=4: send 20 beats → exactly 4 writes, `err_overflow`=1, `instr_count`=4.
- Reset mid-load: assert `rstn`=0 after beat 2 → outputs reset immediately; a new `load_start` then writes addr 0 correctly.
- With `IMEM_LOADER_NOP_FILL_EN` and `DEPTH`=8, load 1 instruction → zero writes to addrs 1..7 on consecutive cycles, then `done`.
